// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: shared constants and state encoding for the round-robin arbiter
package rr_arb4_pkg;
  localparam int N_REQ = 4;
  localparam int DEF_MAX_HOLD = 15;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/prenc.sv
// prenc: 4-input priority encoder, d_i[0] highest priority, code 11 for D0 down to 00 for D3
module prenc (
  input  logic [3:0] d_i,
  output logic       a_o,
  output logic       b_o,
  output logic       y_o
);
  assign y_o = |d_i;
  assign {a_o, b_o} = d_i[0] ? 2'b11 : d_i[1] ? 2'b10 : d_i[2] ? 2'b01 : 2'b00;
endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with registered one-hot grant and hold timeout
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             hold_to
);
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, id_q, id_d, code, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rv;
  logic hold_to_q, hold_to_d, any;
  for (genvar k = 0; k < N_REQ; k++) begin : g_rot
    assign rv[k] = req[ptr_q + 2'(k)];
  end
  prenc u_prenc (.d_i(rv), .a_o(code[1]), .b_o(code[0]), .y_o(any));
  // encoder code 11 means rotated slot 0, so the slot offset is 3 - code
  assign win = ptr_q + (2'd3 - code);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    hold_to_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (any) begin
        state_d = ST_GRANT;
        gnt_d = 4'b0001 << win;
        id_d = win;
        cnt_d = CNT_W'(1);
      end
    end else if (!req[id_q] || cnt_q == CNT_W'(MAX_HOLD)) begin
      state_d = ST_IDLE;
      gnt_d = '0;
      ptr_d = id_q + 2'd1;
      hold_to_d = req[id_q];
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      hold_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      hold_to_q <= hold_to_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_id = id_q;
  assign busy = state_q == ST_GRANT;
  assign hold_to = hold_to_q;
endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed bench for rr_arb4 with a cycle model and literal spot checks
module tb_rr_arb4;
  localparam int MH = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic busy, hold_to;
  int n_chk = 0, n_fail = 0;
  int m_own = -1, m_ptr = 0, m_held = 0, m_to = 0;

  rr_arb4 #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .hold_to(hold_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ownership model: owner index or -1, searched from ptr upward
  always @(posedge clk) begin
    m_to = 0;
    if (rst) begin
      m_own = -1;
      m_ptr = 0;
      m_held = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < 4; k++)
        if (m_own < 0 && req[(m_ptr + k) % 4]) begin
          m_own = (m_ptr + k) % 4;
          m_held = 1;
        end
    end else if (!req[m_own]) begin
      m_ptr = (m_own + 1) % 4;
      m_own = -1;
    end else if (m_held == MH) begin
      m_ptr = (m_own + 1) % 4;
      m_own = -1;
      m_to = 1;
    end else begin
      m_held++;
    end
  end

  always @(negedge clk) begin
    chk("gnt", 32'(gnt), m_own < 0 ? 0 : 1 << m_own);
    chk("busy", 32'(busy), 32'(m_own >= 0));
    chk("hold_to", 32'(hold_to), m_to);
    chk("ptr", 32'(dut.ptr_q), m_ptr);
    if (m_own >= 0) chk("gnt_id", 32'(gnt_id), m_own);
  end

  initial begin
    int id;
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    req = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt), 'h4);
    chk("single_id", 32'(gnt_id), 2);
    chk("single_busy", 32'(busy), 1);
    req = 4'b0000;
    tick();
    chk("release_gnt", 32'(gnt), 0);
    chk("release_ptr", 32'(dut.ptr_q), 3);
    req = 4'b0001;
    tick();
    chk("to_gnt1", 32'(gnt), 'h1);
    tick();
    tick();
    chk("to_gnt3", 32'(gnt), 'h1);
    tick();
    chk("to_revoke", 32'(gnt), 0);
    chk("to_pulse", 32'(hold_to), 1);
    tick();
    chk("to_regrant", 32'(gnt), 'h1);
    chk("to_pulse_end", 32'(hold_to), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1001;
    tick();
    chk("comp_first", 32'(gnt), 'h1);
    tick();
    tick();
    tick();
    chk("comp_to", 32'(hold_to), 1);
    tick();
    chk("comp_p3", 32'(gnt), 'h8);
    tick();
    tick();
    tick();
    chk("comp_to2", 32'(hold_to), 1);
    tick();
    chk("comp_p0", 32'(gnt), 'h1);
    tick();
    tick();
    req = 4'b1000;
    tick();
    chk("coinc_gnt", 32'(gnt), 0);
    chk("coinc_to", 32'(hold_to), 0);
    tick();
    chk("coinc_next", 32'(gnt), 'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      id = int'(gnt_id);
      chk("rr_order", 32'(id), i % 4);
      tick();
      tick();
      req[id] = 1'b0;
      tick();
      chk("rr_idle", 32'(gnt), 0);
      req = 4'b1111;
    end
    tick();
    chk("mid_gnt", 32'(gnt), 'h2);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_id", 32'(gnt_id), 0);
    chk("mid_rst_to", 32'(hold_to), 0);
    rst = 1'b0;
    tick();
    chk("mid_after", 32'(gnt), 'h1);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter that shares one downstream resource between requesters `req[0..3]`. Each arbitration cycle rotates the request vector by a priority pointer, resolves it through the team's 4-input priority encoder, and issues a registered one-hot grant. The grant is held until the owner drops its request or a hold timeout expires. The block sits between the requester ports and the shared resource's select/enable.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive grant cycles per ownership, legal range 1..2^CNT_W-1.
- `CNT_W`, default 4: hold-counter width.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per requester, level, held while the resource is wanted.
- `gnt`  out  4  one-hot registered grant, all zero when idle.
- `gnt_id`  out  2  index of the current owner, valid only when `busy`=1.
- `busy`  out  1  a grant is active.
- `hold_to`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values: `gnt`=0000, `gnt_id`=00, `busy`=0, `hold_to`=0. Internally, `ptr`=0, `cnt`=0, state IDLE.
- `ptr` names the highest-priority requester for the next arbitration.
- Rotation: the rotated vector is `rv[k] = req[(ptr+k) mod 4]`, with `rv[0]` driving encoder input D0 (highest priority) through `rv[3]` driving D3.
- Encoder output: code {A,B} is 11 for D0, 10 for D1, 01 for D2 and 00 for D3. Y is the OR of all inputs.
- Winner index: `win = (ptr + (3 - {A,B})) mod 4`, computed in 2-bit wrap-around arithmetic.
- States:
  - IDLE: if Y=1, go to GRANT; `gnt` is set to onehot(win), `gnt_id` to win, `busy` to 1 and `cnt` to 1. If Y=0, stay in IDLE.
  - GRANT: if `req[gnt_id]`=0, the owner has released. Clear `gnt`/`busy`, set `ptr`=`gnt_id`+1, go to IDLE.
  - GRANT, timeout: else if `cnt`=MAX_HOLD, revoke. Clear `gnt`/`busy`, set `ptr`=`gnt_id`+1, pulse `hold_to` for that one cycle, go to IDLE.
  - GRANT, otherwise: increment `cnt` and keep the grant.
- Release and timeout in the same cycle: release wins and `hold_to` stays 0.
- Requests from non-owners during GRANT are ignored; they are not latched.
- A timed-out owner that keeps `req` high re-enters arbitration at lowest priority, because `ptr` has moved past it.
- `ptr` wraps 3→0.
- Reset asserted mid-grant: all outputs return to reset values on the next edge and `ptr` returns to 0. No `hold_to` pulse is generated.

## Timing
- Grant latency: with `req` rising before edge n while IDLE, `gnt` is valid after edge n, i.e. 1 cycle.
- Release latency: with `req[owner]` falling before edge m, `gnt` is 0 after edge m.
- There is one mandatory idle cycle between ownerships. The earliest next grant comes after edge m+1.
- Maximum ownership is MAX_HOLD cycles with `gnt` high. `hold_to` is high in the cycle immediately after the last granted cycle.
- Worst-case wait for a continuously requesting port is 3·(MAX_HOLD+1) cycles.
- All outputs are registered; there is no combinational path from `req` to any output.

## Structure
- Shared package/header holds:
  - state encoding constants `ST_IDLE`=0 and `ST_GRANT`=1;
  - requester count `N_REQ`=4;
  - default `MAX_HOLD`.
- One sub-module: the existing 4-input priority encoder `prenc`, instantiated once on the rotated vector.
- Rotation, winner arithmetic, counter and FSM live in `rr_arb4`.

## Test plan
- **Reset and single request:**
  - Stimulus: assert `rst` for 2 cycles, then `req`=0100.
  - Response: during reset all outputs are 0. One cycle after the request, `gnt`=0100, `gnt_id`=2 and `busy`=1.
  - Then drop `req`: `gnt`=0000 on the next cycle, and the internal `ptr` becomes 3.
- **Rotation fairness:**
  - Stimulus: hold `req`=1111, with each owner dropping its request for one cycle after 3 granted cycles and re-raising.
  - Response: grant order is 0,1,2,3,0. `gnt` is one-hot at all times, with one idle cycle between owners.
- **Timeout:**
  - Stimulus: set MAX_HOLD=3 and hold `req`=0001 permanently.
  - Response: `gnt`=0001 for exactly 3 cycles, then `gnt`=0000 with `hold_to`=1 for one cycle, then `gnt`=0001 again.
- **Timeout with competitor:**
  - Stimulus: set MAX_HOLD=3 and hold `req`=1001 from reset.
  - Response: port 0 is granted first. After its timeout, port 3 is granted, then port 0 again.
- **Release coinciding with timeout:**
  - Stimulus: the owner drops `req` in the same cycle that `cnt`=MAX_HOLD.
  - Response: `gnt` clears and `hold_to` stays 0.
- **Reset mid-grant:**
  - Stimulus: assert `rst` while `gnt`=0010.
  - Response: after the edge, all outputs are 0. With `req`=1111 afterwards, the first grant goes to port 0.
